// File: rtl/paddle_axis_ctrl.sv
// ---------------------------------------------------------------------------
// paddle_axis_ctrl
//   Digital-to-paddle position integrator. Each channel turns up/down
//   requests (from a joystick/keyboard front end) into a POS_W-bit paddle
//   position that an arcade core consumes as if it came from an analog pot.
//   All channels share one update-rate divider.
//
// Build option:
//   PADDLE_ACCEL_EN  when defined, holding a direction speeds the paddle up
//                    (step 1, then 2, then 4 every ACCEL_HOLD ticks). When it
//                    is undefined, the step is always 1 and the hold
//                    counters / direction tracking are not built.
//
// Ports:
//   clk_sys    system clock (single domain)
//   reset_n    synchronous reset, active low
//   ce         clock enable; the tick divider advances only when ce=1
//   up         [NUM_CH]  per-channel increase request (async source)
//   down       [NUM_CH]  per-channel decrease request (async source)
//   recenter   [NUM_CH]  per-channel recentre request (async source)
//   wrap_mode  0 = saturate at POS_MIN/POS_MAX, 1 = modulo 2**POS_W
//   pos        [NUM_CH*POS_W]  positions, channel i at [i*POS_W +: POS_W]
//   moving     [NUM_CH]  1 while the channel's last tick applied a step
//   tick       one-cycle pulse per update tick
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// paddle_axis_ch
//   One channel of position state. Inputs are already synchronised.
//   Ports: clk_sys, reset_n, tick (update strobe), up_s/down_s/recenter_s
//   (synchronised requests), wrap_mode, pos (position), moving.
// ---------------------------------------------------------------------------
module paddle_axis_ch #(
    parameter int POS_W      = 8,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 2**POS_W-1,
    parameter int CENTER     = 2**(POS_W-1)
`ifdef PADDLE_ACCEL_EN
    ,
    parameter int ACCEL_HOLD = 8
`endif
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             up_s,
    input  logic             down_s,
    input  logic             recenter_s,
    input  logic             wrap_mode,
    output logic [POS_W-1:0] pos,
    output logic             moving
);

    // Three guard bits: enough headroom for a step of up to 4 above the top
    // code, and a sign bit so a step below zero is seen as negative.
    localparam int EXT_W = POS_W + 3;
    localparam logic signed [EXT_W-1:0] MIN_EXT = EXT_W'(POS_MIN);
    localparam logic signed [EXT_W-1:0] MAX_EXT = EXT_W'(POS_MAX);

    logic                    move;
    logic [2:0]              step;
    logic signed [EXT_W-1:0] cur_ext;
    logic signed [EXT_W-1:0] step_ext;
    logic signed [EXT_W-1:0] res;
    logic [POS_W-1:0]        pos_nxt;

    // Exactly one direction requested; both or neither means no motion.
    assign move = up_s ^ down_s;

`ifdef PADDLE_ACCEL_EN
    // hold_q counts consecutive same-direction ticks already applied,
    // saturating at 2*ACCEL_HOLD. k is the 1-based count including the
    // current tick; a reversal (or a fresh start) restarts at k=1.
    localparam int HOLD_W = $clog2(2*ACCEL_HOLD + 2);
    localparam logic [HOLD_W-1:0] HOLD_1 = HOLD_W'(ACCEL_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_2 = HOLD_W'(2*ACCEL_HOLD);

    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] k;
    logic [HOLD_W-1:0] hold_nxt;
    logic              dir_q;    // 1 = last applied step was upward

    always_comb begin
        k        = HOLD_W'(1);
        hold_nxt = HOLD_W'(1);
        step     = 3'd1;
        if (hold_q != '0 && dir_q == up_s)
            k = hold_q + HOLD_W'(1);
        if (k > HOLD_2)
            hold_nxt = HOLD_2;
        else
            hold_nxt = k;
        if (k <= HOLD_1)
            step = 3'd1;
        else if (k <= HOLD_2)
            step = 3'd2;
        else
            step = 3'd4;
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            hold_q <= '0;
            dir_q  <= 1'b0;
        end else if (recenter_s) begin
            hold_q <= '0;
        end else if (tick) begin
            if (move) begin
                hold_q <= hold_nxt;
                dir_q  <= up_s;
            end else begin
                hold_q <= '0;
            end
        end
    end
`else
    assign step = 3'd1;
`endif

    always_comb begin
        cur_ext  = EXT_W'(pos);
        step_ext = EXT_W'(step);
        res      = up_s ? (cur_ext + step_ext) : (cur_ext - step_ext);
        pos_nxt  = res[POS_W-1:0];
        if (!wrap_mode) begin
            if (res > MAX_EXT)
                pos_nxt = POS_W'(POS_MAX);
            else if (res < MIN_EXT)
                pos_nxt = POS_W'(POS_MIN);
        end
    end

    // Recentre is honoured on every edge, not just on ticks, so a short
    // coin/start pulse is never lost between ticks.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            pos    <= POS_W'(CENTER);
            moving <= 1'b0;
        end else if (recenter_s) begin
            pos    <= POS_W'(CENTER);
            moving <= 1'b0;
        end else if (tick) begin
            if (move) begin
                pos    <= pos_nxt;
                moving <= 1'b1;
            end else begin
                moving <= 1'b0;
            end
        end
    end

endmodule

module paddle_axis_ctrl #(
    parameter int NUM_CH     = 2,
    parameter int POS_W      = 8,
    parameter int TICK_DIV   = 16384,
    parameter int POS_MIN    = 0,
    parameter int POS_MAX    = 2**POS_W-1,
    parameter int CENTER     = 2**(POS_W-1),
    parameter int ACCEL_HOLD = 8
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    ce,
    input  logic [NUM_CH-1:0]       up,
    input  logic [NUM_CH-1:0]       down,
    input  logic [NUM_CH-1:0]       recenter,
    input  logic                    wrap_mode,
    output logic [NUM_CH*POS_W-1:0] pos,
    output logic [NUM_CH-1:0]       moving,
    output logic                    tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [NUM_CH-1:0] up_m, up_s;
    logic [NUM_CH-1:0] down_m, down_s;
    logic [NUM_CH-1:0] rc_m, rc_s;
    logic [CNT_W-1:0]  cnt;
    logic [NUM_CH-1:0][POS_W-1:0] pos_arr;

    // Two-flop synchronisers for the asynchronous request lines.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            up_m   <= '0;
            up_s   <= '0;
            down_m <= '0;
            down_s <= '0;
            rc_m   <= '0;
            rc_s   <= '0;
        end else begin
            up_m   <= up;
            up_s   <= up_m;
            down_m <= down;
            down_s <= down_m;
            rc_m   <= recenter;
            rc_s   <= rc_m;
        end
    end

    // Update-rate divider: TICK_DIV ce pulses per tick. tick is registered,
    // so channels update on the edge after the terminal count.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (ce) begin
                if (cnt == CNT_LAST) begin
                    cnt  <= '0;
                    tick <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        paddle_axis_ch #(
            .POS_W      (POS_W),
            .POS_MIN    (POS_MIN),
            .POS_MAX    (POS_MAX),
            .CENTER     (CENTER)
`ifdef PADDLE_ACCEL_EN
            ,
            .ACCEL_HOLD (ACCEL_HOLD)
`endif
        ) u_ch (
            .clk_sys    (clk_sys),
            .reset_n    (reset_n),
            .tick       (tick),
            .up_s       (up_s[i]),
            .down_s     (down_s[i]),
            .recenter_s (rc_s[i]),
            .wrap_mode  (wrap_mode),
            .pos        (pos_arr[i]),
            .moving     (moving[i])
        );
    end

    // Packed array flattens with channel 0 in the low bits.
    assign pos = pos_arr;

endmodule
